encoder_round_scheduler: RTL and testbench
==========================================

Name: encoder_round_scheduler

Overview:
Top-level sequencer for the encoder permutation datapath. It runs each step sub-controller in a fixed order, once per round, for NUM_ROUNDS rounds. The order is column-parity, rotate, permutation, revaluate, add-round-constant. Each step reads one ping-pong state bank and writes the other; the scheduler flips the bank select after every step and publishes the round index for round-constant lookup. A watchdog aborts the run if a sub-controller never returns ready.

Parameters:
NUM_ROUNDS, 24, rounds per run.
NUM_STEPS, 5, step sub-controllers per round; step_idx 0..NUM_STEPS-1 maps to bits of step_start/step_ready.
TIMEOUT, 4096, maximum cycles spent waiting for one step's ready before error.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  run request; a run begins after start goes high, then low.
step_ready  in  NUM_STEPS  one-cycle done pulse from each step sub-controller.
step_start  out  NUM_STEPS  one-cycle start pulse to each step sub-controller (one-hot or zero).
mem_sel  out  1  source bank select; the step reads bank mem_sel and writes bank ~mem_sel.
round_idx  out  5  current round, 0..NUM_ROUNDS-1.
step_idx  out  3  current step, 0..NUM_STEPS-1.
busy  out  1  high in ARM, ISSUE, WAIT, SWAP.
ready  out  1  one-cycle pulse on successful completion.
err  out  1  sticky watchdog-timeout flag.

Behaviour:
- Reset (async, immediate, also mid-run): state=IDLE; step_start=0, mem_sel=0, round_idx=0, step_idx=0, busy=0, ready=0, err=0; watchdog=0.
- States: IDLE, ARM, ISSUE, WAIT, SWAP, DONE, ERR.
- IDLE: start=1 -> ARM; otherwise stay.
- ARM: busy=1; clear err on entry. Stay while start=1. When start=0 -> ISSUE, and load round_idx=0, step_idx=0, mem_sel=0.
- ISSUE: step_start[step_idx]=1 for exactly this cycle, all other bits 0; watchdog cleared -> WAIT.
- WAIT:
  - Only step_ready[step_idx] is sampled; all other bits are ignored.
  - step_ready[step_idx]=1 -> SWAP.
  - Otherwise the watchdog increments; when it reaches TIMEOUT-1 with no ready -> ERR.
  - If ready and timeout occur in the same cycle, ready wins.
- SWAP: mem_sel toggles, then one of:
  - step_idx<NUM_STEPS-1: step_idx++ -> ISSUE.
  - step_idx=NUM_STEPS-1 and round_idx<NUM_ROUNDS-1: step_idx=0, round_idx++ -> ISSUE.
  - Both at maximum: -> DONE; indices hold their final values.
- DONE: ready=1 for one cycle, busy=0 -> IDLE. mem_sel has toggled NUM_ROUNDS*NUM_STEPS times (120 with defaults, so it ends at 0).
- ERR: err=1 (sticky), busy=0, step_start=0; round_idx/step_idx freeze at the failing step. start=1 -> ARM, which clears err.
- start is ignored while busy; no re-arm mid-run.
- Latency:
  - Per step: 1 (ISSUE) + N WAIT cycles + 1 (SWAP), where N is the cycle count until ready (N=1 if ready arrives in the first WAIT cycle).
  - Default run with immediate ready: 120*3 = 360 cycles from the ARM exit edge to DONE entry; ready is asserted in the next cycle.
- Outputs are decoded from state plus registers; no output depends combinationally on step_ready or start.
- round_idx and step_idx are registered and stable for the whole of ISSUE/WAIT.

Test Plan:
- Nominal run, model acks each step_start with step_ready 1 cycle later: exactly 120 step_start pulses in order 0,1,2,3,4 repeating; round_idx 0..23; mem_sel toggles after every ack and ends at 0; one ready pulse 361 cycles after start falls; err=0.
- Variable latency, step 2 acks after 50 cycles and others after 3: ordering unchanged; busy high throughout; no duplicate step_start pulses.
- Spurious acks: pulse step_ready[4] while waiting on step 1 -> ignored, state stays WAIT; the correct step_ready[1] then advances to step 2.
- Watchdog with TIMEOUT=16, round 3 step 3 never acks: err=1 after 16 WAIT cycles; busy=0; round_idx=3, step_idx=3 frozen; no ready. A new start then clears err and completes a full run.
- Async rst asserted mid-WAIT in round 10: all outputs 0 immediately (before the next clock edge); start held high during the run is ignored, and a fresh start/release afterwards restarts from round 0 with mem_sel=0.

Source files
------------

// File: rtl/encoder_round_scheduler.sv
// encoder_round_scheduler: sequences the step sub-controllers round by round over ping-pong state banks, with a per-step watchdog.
module encoder_round_scheduler #(
  parameter int NUM_ROUNDS = 24,
  parameter int NUM_STEPS  = 5,
  parameter int TIMEOUT    = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_STEPS-1:0] step_ready,
  output logic [NUM_STEPS-1:0] step_start,
  output logic                 mem_sel,
  output logic [4:0]           round_idx,
  output logic [2:0]           step_idx,
  output logic                 busy,
  output logic                 ready,
  output logic                 err
);
  localparam int WW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, ARM, ISSUE, WAIT, SWAP, DONE, ERR} state_t;
  state_t state;
  logic [WW-1:0] wd;
  logic last_step, last_round;
  always_comb begin
    last_step = step_idx == 3'(NUM_STEPS - 1);
    last_round = round_idx == 5'(NUM_ROUNDS - 1);
  end
  // Outputs are registered alongside the state so each one is valid for exactly the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      step_start <= '0;
      mem_sel <= 1'b0;
      round_idx <= '0;
      step_idx <= '0;
      busy <= 1'b0;
      ready <= 1'b0;
      err <= 1'b0;
      wd <= '0;
    end else begin
      step_start <= '0;
      ready <= 1'b0;
      case (state)
        IDLE, ERR: if (start) begin
          state <= ARM;
          busy <= 1'b1;
          err <= 1'b0;
        end
        ARM: if (!start) begin
          state <= ISSUE;
          round_idx <= '0;
          step_idx <= '0;
          mem_sel <= 1'b0;
          step_start <= NUM_STEPS'(1);
        end
        ISSUE: begin
          wd <= '0;
          state <= WAIT;
        end
        WAIT: if (step_ready[step_idx]) state <= SWAP;
          else if (wd == WW'(TIMEOUT - 1)) begin
            state <= ERR;
            err <= 1'b1;
            busy <= 1'b0;
          end else wd <= wd + 1'b1;
        SWAP: begin
          mem_sel <= ~mem_sel;
          if (last_step && last_round) begin
            state <= DONE;
            ready <= 1'b1;
            busy <= 1'b0;
          end else begin
            state <= ISSUE;
            step_idx <= last_step ? 3'd0 : step_idx + 3'd1;
            round_idx <= last_step ? round_idx + 5'd1 : round_idx;
            step_start <= last_step ? NUM_STEPS'(1) : NUM_STEPS'(1) << (step_idx + 3'd1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_encoder_round_scheduler.sv
// tb_encoder_round_scheduler: randomized sub-controller responder with a queued scoreboard of expected step/ready/err events.
module tb_encoder_round_scheduler;
  localparam int NR = 24, NS = 5, TO = 64, TOT = NR * NS;
  logic clk = 0, rst = 0, start = 0;
  logic [NS-1:0] step_ready = '0, step_start;
  logic mem_sel, busy, ready, err;
  logic [4:0] round_idx;
  logic [2:0] step_idx;
  encoder_round_scheduler #(.NUM_ROUNDS(NR), .NUM_STEPS(NS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .step_ready(step_ready), .step_start(step_start),
    .mem_sel(mem_sel), .round_idx(round_idx), .step_idx(step_idx), .busy(busy), .ready(ready), .err(err));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int kind; int r; int s; int m; int t;} ev_t;
  ev_t exp_q[$];
  int checks = 0, errors = 0;
  int lats[TOT];
  int stall = -1, seen = 0, last_start = 0;
  bit spur = 0;
  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, want, cyc);
    end
  endtask
  task automatic take(input int kind, output ev_t e, output bit ok);
    ok = exp_q.size() > 0 && exp_q[0].kind == kind;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL event_order: got event kind %0d expected kind %0d at cycle %0d", kind,
               exp_q.size() > 0 ? exp_q[0].kind : -1, cyc);
    end else e = exp_q.pop_front();
  endtask
  // Sub-controller model: acks each start after its latency; in spurious mode other bits toggle randomly meanwhile.
  initial begin
    int cnt = 0, ps = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = 0;
        step_ready = '0;
      end else begin
        step_ready = (spur && cnt > 0) ? NS'($urandom) & ~(NS'(1) << ps) : '0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) step_ready[ps] = 1'b1;
        end
        if (|step_start) begin
          ps = seen % NS;
          cnt = (seen == stall || seen >= TOT) ? 0 : lats[seen];
          seen++;
        end
      end
    end
  end
  initial begin
    bit err_d = 0, ok;
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (|step_start) begin
          take(0, e, ok);
          last_start = cyc;
          if (ok) begin
            chk("step_start", int'(step_start), 1 << e.s);
            chk("round_idx", int'(round_idx), e.r);
            chk("step_idx", int'(step_idx), e.s);
            chk("mem_sel", int'(mem_sel), e.m);
            chk("busy_run", int'(busy), 1);
          end
        end
        if (ready) begin
          take(1, e, ok);
          if (ok) begin
            chk("ready_time", cyc, e.t);
            chk("final_mem_sel", int'(mem_sel), e.m);
            chk("final_round", int'(round_idx), e.r);
            chk("final_step", int'(step_idx), e.s);
            chk("busy_done", int'(busy), 0);
            chk("err_done", int'(err), 0);
          end
        end
        if (err && !err_d) begin
          take(2, e, ok);
          if (ok) begin
            chk("err_time", cyc - last_start, TO + 1);
            chk("err_round", int'(round_idx), e.r);
            chk("err_step", int'(step_idx), e.s);
            chk("busy_err", int'(busy), 0);
            chk("start_err", int'(step_start), 0);
          end
        end
      end
      err_d = err;
    end
  end
  task automatic outs_zero(input string tag);
    chk({tag, "_step_start"}, int'(step_start), 0);
    chk({tag, "_mem_sel"}, int'(mem_sel), 0);
    chk({tag, "_round_idx"}, int'(round_idx), 0);
    chk({tag, "_step_idx"}, int'(step_idx), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ready"}, int'(ready), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask
  // mode 0: ack after 1; mode 1: step 2 after 50, others 3; mode 2: random 1..6 plus spurious acks.
  task automatic run(input int mode, input int stall_i, input int abort_i);
    int t = 0, c;
    seen = 0;
    stall = stall_i;
    spur = mode == 2;
    for (int i = 0; i < TOT; i++)
      lats[i] = mode == 0 ? 1 : mode == 1 ? (i % NS == 2 ? 50 : 3) : int'($urandom_range(1, 6));
    start = 1;
    repeat (2) @(negedge clk);
    chk("arm_busy", int'(busy), 1);
    chk("arm_err_clear", int'(err), 0);
    @(negedge clk);
    start = 0;
    c = cyc;
    for (int i = 0; i < TOT; i++) begin
      if (stall_i >= 0 && i > stall_i) break;
      exp_q.push_back('{0, i / NS, i % NS, i % 2, 0});
      t += lats[i] + 2;
    end
    if (stall_i < 0) exp_q.push_back('{1, NR - 1, NS - 1, TOT % 2, c + t + 1});
    else exp_q.push_back('{2, stall_i / NS, stall_i % NS, 0, 0});
    if (abort_i >= 0) begin
      repeat (4) @(negedge clk);
      start = 1;
      for (int i = 0; i < 5000 && seen <= abort_i; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      chk("pre_rst_busy", int'(busy), 1);
      chk("pre_rst_round", int'(round_idx), abort_i / NS);
      #2 rst = 1;
      #1 outs_zero("async_rst");
      @(negedge clk);
      exp_q.delete();
      rst = 0;
      return;
    end
    for (int i = 0; i < 5000 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("drain", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("idle_busy", int'(busy), 0);
  endtask
  initial begin
    rst = 1;
    #1 outs_zero("reset");
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    run(0, -1, -1);
    run(1, -1, -1);
    run(2, -1, -1);
    run(0, 3 * NS + 3, -1);
    chk("err_sticky", int'(err), 1);
    run(0, -1, -1);
    run(1, -1, 10 * NS + 2);
    run(0, -1, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
